// File: rtl/cmerge2_sync_cache_pkg.sv
// Shared definitions for the two-way clocked merge in the cache control path.
package cmerge2_sync_cache_pkg;

    // Default flip-flop depth of each input synchronizer (2..4 are sensible).
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Merge sequencing: wait for work, send one downstream event, wait for its
    // acknowledge, then hand the acknowledge back to the granted branch.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/cmerge2_sync_cache_if.sv
// Two-phase handshake bundle of the merge: two upstream branches and one
// downstream stage, plus status outputs.
interface cmerge2_sync_cache_if;
    logic i_drive0;
    logic i_drive1;
    logic i_freeNext;
    logic o_free0;
    logic o_free1;
    logic o_driveNext;
    logic o_fire;
    logic o_sel;
    logic o_busy;
    logic o_err;

    // The merge itself receives requests and the downstream acknowledge.
    modport slave (
        input  i_drive0, i_drive1, i_freeNext,
        output o_free0, o_free1, o_driveNext, o_fire, o_sel, o_busy, o_err
    );

    // The environment around the merge drives the toggle lines.
    modport master (
        output i_drive0, i_drive1, i_freeNext,
        input  o_free0, o_free1, o_driveNext, o_fire, o_sel, o_busy, o_err
    );
endinterface

// File: rtl/cmerge2_sync_cache_toggle_sync_edge.sv
// Brings one asynchronous two-phase toggle line into the clk domain and turns
// every toggle into a single-cycle pulse.
module toggle_sync_edge
    import cmerge2_sync_cache_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic toggle_in,
    output logic edge_pulse
);

    logic [STAGES-1:0] sync_q;
    logic              last_seen;

    // Shift the raw line through the synchronizer and remember the last
    // synchronized level so that a change is reported exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            last_seen <= 1'b0;
        end else begin
            sync_q    <= {sync_q[STAGES-2:0], toggle_in};
            last_seen <= sync_q[STAGES-1];
        end
    end

    assign edge_pulse = sync_q[STAGES-1] ^ last_seen;

endmodule

// File: rtl/cmerge2_sync_cache.sv
// Clocked 2-to-1 merge: forwards one upstream drive event at a time to the
// downstream stage and returns the downstream free to the granted branch only.
module cmerge2_sync_cache
    import cmerge2_sync_cache_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input logic clk,
    input logic rst,
    cmerge2_sync_cache_if.slave bus
);

    logic       drive_edge0;
    logic       drive_edge1;
    logic       free_edge;
    state_t     state;
    state_t     state_next;
    logic       start_issue;
    logic       do_release;
    logic       winner;
    logic [1:0] pend;
    logic       prio;
    logic       drive_next_q;
    logic [1:0] free_q;
    logic       fire_q;
    logic       sel_q;
    logic       busy_q;
    logic       err_q;

    toggle_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_drive0 (
        .clk        (clk),
        .rst        (rst),
        .toggle_in  (bus.i_drive0),
        .edge_pulse (drive_edge0)
    );

    toggle_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_drive1 (
        .clk        (clk),
        .rst        (rst),
        .toggle_in  (bus.i_drive1),
        .edge_pulse (drive_edge1)
    );

    toggle_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_free (
        .clk        (clk),
        .rst        (rst),
        .toggle_in  (bus.i_freeNext),
        .edge_pulse (free_edge)
    );

    // With both branches waiting the round-robin pointer decides; otherwise
    // the only waiting branch is chosen.
    assign winner = (pend == 2'b11) ? prio : pend[1];

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the two one-cycle actions (grant and hand-back).
    always_comb begin
        state_next  = state;
        start_issue = 1'b0;
        do_release  = 1'b0;
        case (state)
            IDLE: begin
                if (pend != 2'b00) begin
                    state_next  = ISSUE;
                    start_issue = 1'b1;
                end
            end
            ISSUE: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (free_edge) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
                do_release = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Toggle the downstream request on grant and the granted branch's free on
    // release; track the grant, busy window and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drive_next_q <= 1'b0;
            free_q       <= 2'b00;
            fire_q       <= 1'b0;
            sel_q        <= 1'b0;
            busy_q       <= 1'b0;
            prio         <= 1'b0;
        end else begin
            fire_q <= start_issue;
            if (start_issue) begin
                drive_next_q <= ~drive_next_q;
                sel_q        <= winner;
                busy_q       <= 1'b1;
            end
            if (do_release) begin
                free_q[sel_q] <= ~free_q[sel_q];
                busy_q        <= 1'b0;
                prio          <= ~sel_q;
            end
        end
    end

    // A branch stays pending from its drive edge until its transfer is
    // released; a repeated edge while pending is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 2'b00;
        end else begin
            if (do_release && !sel_q) begin
                pend[0] <= 1'b0;
            end else if (drive_edge0 && !pend[0]) begin
                pend[0] <= 1'b1;
            end
            if (do_release && sel_q) begin
                pend[1] <= 1'b0;
            end else if (drive_edge1 && !pend[1]) begin
                pend[1] <= 1'b1;
            end
        end
    end

    // Sticky flag for double requests and acknowledges nobody waits for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((drive_edge0 && pend[0]) || (drive_edge1 && pend[1]) ||
                     (free_edge && (state != WAIT_ACK))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_driveNext = drive_next_q;
    assign bus.o_free0     = free_q[0];
    assign bus.o_free1     = free_q[1];
    assign bus.o_fire      = fire_q;
    assign bus.o_sel       = sel_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_cmerge2_sync_cache.sv
// Bench for the clocked 2-to-1 merge: runs a 2-stage and a 3-stage instance
// side by side against an event-level reference model, plus literal checks.
module tb_cmerge2_sync_cache;

    typedef struct packed {
        logic [7:0] h0;
        logic [7:0] h1;
        logic [7:0] hf;
        logic [1:0] pend;
        logic [1:0] mode;
        logic       sel;
        logic       prio;
        logic       drv;
        logic       f0;
        logic       f1;
        logic       fire;
        logic       busy;
        logic       err;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drive0 = 1'b0;
    logic drive1 = 1'b0;
    logic freeNext = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   edgeCount = 0;
    bit   checkEnable = 1'b0;
    model_t m2;
    model_t m3;
    logic [6:0] out2;
    logic [6:0] out3;

    cmerge2_sync_cache_if bus2 ();
    cmerge2_sync_cache_if bus3 ();

    assign bus2.i_drive0   = drive0;
    assign bus2.i_drive1   = drive1;
    assign bus2.i_freeNext = freeNext;
    assign bus3.i_drive0   = drive0;
    assign bus3.i_drive1   = drive1;
    assign bus3.i_freeNext = freeNext;

    cmerge2_sync_cache #(.SYNC_STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    cmerge2_sync_cache #(.SYNC_STAGES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign out2 = {bus2.o_driveNext, bus2.o_free0, bus2.o_free1, bus2.o_fire,
                   bus2.o_sel, bus2.o_busy, bus2.o_err};
    assign out3 = {bus3.o_driveNext, bus3.o_free0, bus3.o_free1, bus3.o_fire,
                   bus3.o_sel, bus3.o_busy, bus3.o_err};

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Reference: a toggle sampled at edge n is acted on at edge n+stages.
    // Modes: 0 waiting for work, 1 just granted, 2 awaiting ack, 3 handing back.
    function automatic model_t modelStep(model_t m, int stages, logic d0, logic d1, logic fn);
        logic       e0, e1, ef;
        logic [1:0] pendBefore;
        logic [1:0] modeBefore;
        m.h0 = {m.h0[6:0], d0};
        m.h1 = {m.h1[6:0], d1};
        m.hf = {m.hf[6:0], fn};
        e0 = m.h0[stages] != m.h0[stages+1];
        e1 = m.h1[stages] != m.h1[stages+1];
        ef = m.hf[stages] != m.hf[stages+1];
        pendBefore = m.pend;
        modeBefore = m.mode;
        m.fire = 1'b0;
        if (modeBefore == 2'd0 && pendBefore != 2'b00) begin
            m.sel  = (pendBefore == 2'b11) ? m.prio : pendBefore[1];
            m.drv  = ~m.drv;
            m.fire = 1'b1;
            m.busy = 1'b1;
            m.mode = 2'd1;
        end else if (modeBefore == 2'd1) begin
            m.mode = 2'd2;
        end else if (modeBefore == 2'd2 && ef) begin
            m.mode = 2'd3;
        end else if (modeBefore == 2'd3) begin
            if (m.sel) m.f1 = ~m.f1;
            else       m.f0 = ~m.f0;
            m.pend[m.sel] = 1'b0;
            m.busy = 1'b0;
            m.prio = ~m.sel;
            m.mode = 2'd0;
        end
        if (ef && modeBefore != 2'd2) m.err = 1'b1;
        if (e0) begin
            if (pendBefore[0]) m.err = 1'b1;
            else               m.pend[0] = 1'b1;
        end
        if (e1) begin
            if (pendBefore[1]) m.err = 1'b1;
            else               m.pend[1] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [6:0] modelOut(model_t m);
        return {m.drv, m.f0, m.f1, m.fire, m.sel, m.busy, m.err};
    endfunction

    // Advance both reference models on every clock, clearing them on reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m2 <= '0;
            m3 <= '0;
        end else begin
            m2 <= modelStep(m2, 2, drive0, drive1, freeNext);
            m3 <= modelStep(m3, 3, drive0, drive1, freeNext);
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at t=%0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // Compare every cycle of both instances with the reference models.
    always @(negedge clk) begin
        if (checkEnable) begin
            checkOutput("cycle_s2", {1'b0, out2}, {1'b0, modelOut(m2)});
            checkOutput("cycle_s3", {1'b0, out3}, {1'b0, modelOut(m3)});
        end
    end

    task automatic atEdge(input int n);
        while (edgeCount < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        drive0 = 1'b0;
        drive1 = 1'b0;
        freeNext = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Serve count transfers on the 2-stage instance, acknowledging each one;
    // optionally the served branch asks again right after its free returns.
    task automatic runTransfers(input int count, input bit reRequest,
                                output logic [7:0] sels, output int fires);
        bit got;
        sels = '0;
        fires = 0;
        for (int t = 0; t < count; t++) begin
            got = 1'b0;
            for (int c = 0; c < 80 && !got; c++) begin
                @(posedge clk);
                #1;
                if (bus2.o_fire) got = 1'b1;
            end
            if (!got) begin
                checkOutput("fire_wait", 8'd0, 8'd1);
                return;
            end
            sels[t] = bus2.o_sel;
            fires++;
            @(negedge clk);
            @(negedge clk);
            freeNext = ~freeNext;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(posedge clk);
                #1;
                if (!bus2.o_busy) got = 1'b1;
            end
            if (!got) begin
                checkOutput("release_wait", 8'd0, 8'd1);
                return;
            end
            if (reRequest) begin
                @(negedge clk);
                if (sels[t]) drive1 = ~drive1;
                else         drive0 = ~drive0;
            end
        end
    endtask

    // Random traffic: branches request when idle, downstream acks when owed,
    // with occasional protocol violations thrown in.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 20 && drive0 == bus2.o_free0) drive0 = ~drive0;
            if ($urandom_range(0, 99) < 20 && drive1 == bus2.o_free1) drive1 = ~drive1;
            if (bus2.o_busy && bus2.o_driveNext != freeNext && $urandom_range(0, 99) < 30)
                freeNext = ~freeNext;
            if ($urandom_range(0, 999) < 3) freeNext = ~freeNext;
            if ($urandom_range(0, 999) < 3) drive0 = ~drive0;
        end
    endtask

    initial begin
        int k;
        int j;
        int fires;
        int extra;
        logic [7:0] sels;

        // Reset state
        repeat (2) @(negedge clk);
        checkEnable = 1'b1;
        #1;
        checkOutput("reset_s2", {1'b0, out2}, 8'd0);
        checkOutput("reset_s3", {1'b0, out3}, 8'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // Single branch-0 event and its acknowledge
        @(negedge clk);
        drive0 = 1'b1;
        k = edgeCount + 1;
        atEdge(k + 2);
        checkOutput("single_pre_s2", {1'b0, out2}, 8'b0000000);
        atEdge(k + 3);
        checkOutput("single_issue_s2", {1'b0, out2}, 8'b01001010);
        checkOutput("single_model_s2", {1'b0, modelOut(m2)}, 8'b01001010);
        checkOutput("single_pre_s3", {1'b0, out3}, 8'b0000000);
        atEdge(k + 4);
        checkOutput("single_after_s2", {1'b0, out2}, 8'b01000010);
        checkOutput("single_issue_s3", {1'b0, out3}, 8'b01001010);
        atEdge(k + 9);
        @(negedge clk);
        freeNext = 1'b1;
        j = edgeCount + 1;
        atEdge(j + 2);
        checkOutput("free_pre_s2", {1'b0, out2}, 8'b01000010);
        atEdge(j + 3);
        checkOutput("free_done_s2", {1'b0, out2}, 8'b01100000);
        checkOutput("free_pre_s3", {1'b0, out3}, 8'b01000010);
        atEdge(j + 4);
        checkOutput("free_done_s3", {1'b0, out3}, 8'b01100000);

        // Simultaneous requests
        applyReset();
        @(negedge clk);
        drive0 = 1'b1;
        drive1 = 1'b1;
        runTransfers(2, 1'b0, sels, fires);
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus2.o_fire) extra++;
        end
        checkOutput("simul_order", {6'd0, sels[1:0]}, 8'b10);
        checkOutput("simul_fires", 8'(fires + extra), 8'd2);
        checkOutput("simul_end_s2", {1'b0, out2}, 8'b00110100);
        checkOutput("simul_end_s3", {1'b0, out3}, 8'b00110100);

        // Round-robin fairness under constant demand
        applyReset();
        @(negedge clk);
        drive0 = 1'b1;
        drive1 = 1'b1;
        runTransfers(8, 1'b1, sels, fires);
        checkOutput("rr_sequence", sels, 8'b10101010);
        checkOutput("rr_no_err", {7'd0, bus2.o_err}, 8'd0);

        // Second branch-0 request before its free
        applyReset();
        @(negedge clk);
        drive0 = 1'b1;
        k = edgeCount + 1;
        atEdge(k + 4);
        @(negedge clk);
        drive0 = 1'b0;
        atEdge(k + 8);
        checkOutput("dup_err_s2", {1'b0, out2}, 8'b01000011);
        @(negedge clk);
        freeNext = 1'b1;
        atEdge(k + 24);
        checkOutput("dup_once_s2", {1'b0, out2}, 8'b01100001);
        checkOutput("dup_once_s3", {1'b0, out3}, 8'b01100001);

        // Spurious downstream acknowledge while idle
        applyReset();
        @(negedge clk);
        freeNext = 1'b1;
        j = edgeCount + 1;
        atEdge(j + 6);
        checkOutput("spurious_s2", {1'b0, out2}, 8'b00000001);
        checkOutput("spurious_s3", {1'b0, out3}, 8'b00000001);

        // Reset while waiting for the acknowledge, then a normal branch-1 event
        applyReset();
        @(negedge clk);
        drive1 = 1'b1;
        k = edgeCount + 1;
        atEdge(k + 6);
        checkOutput("midop_busy_s2", {7'd0, bus2.o_busy}, 8'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        drive0 = 1'b0;
        drive1 = 1'b0;
        freeNext = 1'b0;
        #1;
        checkOutput("async_reset_s2", {1'b0, out2}, 8'd0);
        checkOutput("async_reset_s3", {1'b0, out3}, 8'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        drive1 = 1'b1;
        k = edgeCount + 1;
        atEdge(k + 3);
        checkOutput("after_reset_s2", {1'b0, out2}, 8'b01001110);
        atEdge(k + 4);
        checkOutput("after_reset_s3", {1'b0, out3}, 8'b01001110);

        // Randomized traffic against the reference models
        applyReset();
        applyStimulus(2000);
        repeat (20) @(negedge clk);

        checkEnable = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cmerge2_sync_cache.md
Name: cmerge2_sync_cache

Overview:
- Clocked 2-to-1 merge for the cache control path; the counterpart of the two-way selector.
- Accepts drive events from two upstream branches (a selector's two driveNext outputs or any two click-stage senders) and forwards one event at a time to a single downstream stage.
- Returns the downstream free event only to the branch that was granted.
- All handshake lines are 2-phase: each toggle is one event. Inputs are asynchronous to clk and are synchronized inside the block.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchronizer (legal range 2..4)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_drive0  input  1  branch 0 request; toggle = one event
i_drive1  input  1  branch 1 request; toggle = one event
o_free0  output  1  branch 0 acknowledge; toggles once per completed branch-0 transfer
o_free1  output  1  branch 1 acknowledge; toggles once per completed branch-1 transfer
o_driveNext  output  1  downstream request; toggles once per granted event
i_freeNext  input  1  downstream acknowledge; toggle = one event
o_fire  output  1  one-cycle pulse in the cycle o_driveNext toggles
o_sel  output  1  branch currently or last granted (0/1); valid while o_busy is high
o_busy  output  1  high from grant until branch release
o_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release on clk): all synchronizer flops, last-seen copies, pend flags, o_free0/1, o_driveNext = 0; o_fire = 0; o_sel = 0; o_busy = 0; o_err = 0; FSM = IDLE; round-robin priority points to branch 0.
- Reset mid-operation abandons any in-flight event. Upstream and downstream stages share rst, so every toggle line restarts at 0.
- Synchronizers: i_drive0, i_drive1 and i_freeNext each pass through SYNC_STAGES flops.
- Edge detect: synchronized value differs from the registered last-seen copy. On detection the copy is updated in the same cycle.
- pend0/pend1: set on a branch drive edge; cleared in RELEASE for the granted branch.
- A drive edge on a branch whose pend flag is already set sets o_err. The event is dropped; pend stays 1.
- FSM states and transitions:
  - IDLE: if any pend is set and no grant is active, go to ISSUE.
    - One pending branch: that branch wins.
    - Both pending: the branch not granted last wins.
  - ISSUE (one cycle): toggle o_driveNext, pulse o_fire, set o_busy, latch o_sel, then go to WAIT_ACK.
  - WAIT_ACK: on a detected i_freeNext edge, go to RELEASE. With no edge, stay indefinitely; there is no timeout.
  - RELEASE (one cycle): toggle o_free[o_sel], clear pend[o_sel], clear o_busy, move priority to the other branch, then go to IDLE.
- Latency, with input toggle at sync flop 0 on edge k:
  - pend set at edge k+SYNC_STAGES.
  - o_driveNext toggles and o_fire is high at edge k+SYNC_STAGES+1.
  - The freeNext → o_free path has the same latency: o_free toggles SYNC_STAGES+1 edges after i_freeNext is first sampled.
- Simultaneous events:
  - Both drive edges detected in the same cycle: both pends are set and round-robin decides; back-to-back service follows with no idle gap beyond the IDLE cycle.
  - A drive edge on the other branch during WAIT_ACK is held in pend and served after RELEASE.
- An i_freeNext edge outside WAIT_ACK is a protocol violation: set o_err, ignore the event.
- Throughput: at most one transfer per (SYNC_STAGES+3) cycles plus downstream ack time.

Decomposition:
- Shared package (cache control pkg) holds:
  - FSM state encoding (IDLE, ISSUE, WAIT_ACK, RELEASE, 2 bits).
  - The SYNC_STAGES default constant.
- One sub-module, toggle_sync_edge: SYNC_STAGES synchronizer plus last-seen register, producing a one-cycle edge pulse. It is instantiated three times.

Test Plan:
- Reset check: after reset, all outputs are 0 and the FSM is in IDLE. Assert rst while in WAIT_ACK → all outputs return to 0 asynchronously, and the next i_drive1 toggle is served normally.
- Single branch-0 event, SYNC_STAGES=2: toggle i_drive0 at cycle 0.
  - o_driveNext goes 0→1 with o_fire=1, o_sel=0 at cycle 3.
  - Toggle i_freeNext at cycle 10 → o_free0 goes 0→1 at cycle 13, o_busy falls, o_free1 is unchanged.
- Simultaneous requests: toggle i_drive0 and i_drive1 in the same cycle after reset.
  - Branch 0 is granted first (o_sel=0), branch 1 second.
  - Exactly two o_fire pulses; o_free0 and o_free1 each toggle once.
- Round-robin fairness: keep both branches re-requesting immediately after each free, for 8 transfers → o_sel sequence is 0,1,0,1,0,1,0,1.
- Protocol violations, each checked with o_err=1 and the event ignored:
  - Second i_drive0 toggle before o_free0 → o_driveNext toggles only once for branch 0.
  - Spurious i_freeNext toggle while in IDLE → no o_free toggle.
- Parameter sweep, SYNC_STAGES=3: repeat the single-event test → o_driveNext toggles at cycle 4 and o_free0 toggles 4 cycles after i_freeNext.
